fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the program counter, drives the instruction-memory address, and registers fetched instruction and PC+4 into the decode stage where the main decoder consumes the opcode.
- Implements stall, branch/jump redirect with flush, and a sticky halt driven by the decoder's load signal.

Parameters:
- WIDTH, 32, datapath/address width in bits.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 0, bubble instruction inserted on flush/halt (opcode 0 = R-type sll $0 nop, decodes to regwrite to $0 only).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  WIDTH  instruction memory address, combinationally equal to pc_f.
- imem_rdata  input  WIDTH  instruction word, asynchronous read, valid same cycle as imem_addr.
- stall  input  1  from hazard unit; freezes PC and IF/ID.
- redirect  input  1  taken branch or jump resolved in decode.
- redirect_pc  input  WIDTH  target address for redirect.
- load  input  1  from main decoder; 0 means HALT is in decode.
- pc_f  output  WIDTH  current fetch PC.
- instr_d  output  WIDTH  registered instruction to decode.
- pc_plus4_d  output  WIDTH  registered PC+4 of instr_d.
- valid_d  output  1  instr_d is a real fetched instruction (0 = bubble).
- halted  output  1  sticky halt flag.

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-stall/mid-redirect/halted):
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, halted=0.
- PC+4 computed modulo 2^WIDTH: 0xFFFFFFFC+4 = 0x00000000, no error.
- redirect_pc bits [1:0] forced to 0 before loading PC.
- Per-edge priority, rst=0:
  - halted=1: PC, instr_d, pc_plus4_d, valid_d all hold; inputs ignored.
  - load=0 and valid_d=1: set halted=1, PC holds, IF/ID loads bubble (NOP_INSTR, valid_d=0, pc_plus4_d holds). Takes effect regardless of stall/redirect. load=0 with valid_d=0 is ignored.
  - stall=1: PC and IF/ID hold. Redirect is ignored; the hazard unit re-presents it after the stall.
  - redirect=1: PC<=redirect_pc aligned, IF/ID loads bubble (flush of wrong-path fetch).
  - Otherwise: PC<=PC+4, instr_d<=imem_rdata, pc_plus4_d<=PC+4, valid_d<=1.
- Latency:
  - Instruction at PC appears on instr_d one cycle after PC is presented.
  - Redirect target is fetched in the cycle after redirect, so one bubble per taken branch/jump.
- State machine, 2 states:
  - RUN -> HALT on the halt condition above.
  - HALT -> RUN only on rst.
  - halted = (state==HALT).
- No X propagation: imem_rdata is captured only on the normal-advance path.

Test Plan:
- Reset then free-run, imem returns addr-based words: pc_f 0,4,8,12 on successive cycles; instr_d lags by 1 cycle; valid_d=0 in first cycle after reset, then 1; pc_plus4_d=4,8,12.
- stall=1 for 3 cycles at pc_f=0x10: pc_f, instr_d, pc_plus4_d frozen 3 cycles; resume at 0x14 with no instruction lost or duplicated.
- redirect=1, redirect_pc=0x43 at pc_f=0x20: next pc_f=0x40; instr_d=0, valid_d=0 for one cycle; then instr_d=word(0x40), pc_plus4_d=0x44.
- redirect=1 and stall=1 simultaneously: PC and IF/ID hold (redirect ignored); redirect alone next cycle takes effect normally.
- load=0 with valid_d=1: halted=1 next edge, instr_d=0, valid_d=0, pc_f frozen; redirect/stall pulses afterwards change nothing; rst=1 returns pc_f=RESET_PC, halted=0.
- PC wrap, RESET_PC=0xFFFFFFF8: pc_f 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; pc_plus4_d=0 for the 0xFFFFFFFC instruction.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Read is asynchronous: rdata is valid in the same cycle as addr.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register: PC, stall, redirect with flush,
// and a sticky halt raised when HALT reaches decode.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WIDTH-1:0]  redirect_pc,
    input  logic              load,
    output logic [WIDTH-1:0]  pc_f,
    output logic [WIDTH-1:0]  instr_d,
    output logic [WIDTH-1:0]  pc_plus4_d,
    output logic              valid_d,
    output logic              halted
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] pc_plus4_f;
    logic [WIDTH-1:0] target;

    assign imem.imem_addr = pc_f;
    assign pc_plus4_f     = pc_f + WIDTH'(4);
    assign target         = {redirect_pc[WIDTH-1:2], 2'b00};
    assign halted         = (state == S_HALT);

    // Halt only counts when decode holds a real instruction; a bubble's
    // load=0 is meaningless. Halt outranks stall and redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            pc_f       <= RESET_PC;
            instr_d    <= NOP_INSTR;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (state == S_HALT) begin
            state      <= S_HALT;
        end else if (!load && valid_d) begin
            state      <= S_HALT;
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end else if (stall) begin
            state      <= S_RUN;
        end else if (redirect) begin
            pc_f       <= target;
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end else begin
            pc_f       <= pc_plus4_f;
            instr_d    <= imem.imem_rdata;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID state is queued per step
// and checked after the edge; a second instance covers PC wrap-around.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        load = 1'b1;

    logic [31:0] pc_f_a, instr_d_a, p4_d_a;
    logic        valid_a, halted_a;
    logic [31:0] pc_f_b, instr_d_b, p4_d_b;
    logic        valid_b, halted_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          dut_b;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        bit          chk_p4;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    fetch_stage_if #(.WIDTH(32)) bus_a ();
    fetch_stage_if #(.WIDTH(32)) bus_b ();
    assign bus_a.imem_rdata = word(bus_a.imem_addr);
    assign bus_b.imem_rdata = word(bus_b.imem_addr);

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut_a (
        .clk(clk), .rst(rst), .imem(bus_a.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .load(load),
        .pc_f(pc_f_a), .instr_d(instr_d_a), .pc_plus4_d(p4_d_a),
        .valid_d(valid_a), .halted(halted_a)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0)) dut_b (
        .clk(clk), .rst(rst), .imem(bus_b.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .load(load),
        .pc_f(pc_f_b), .instr_d(instr_d_b), .pc_plus4_d(p4_d_b),
        .valid_d(valid_b), .halted(halted_b)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then check.
    task automatic step(input string tag, input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic ld, input bit which,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_p4, input bit e_chk_p4,
                        input logic e_valid, input logic e_halted);
        exp_t e;
        e.dut_b = which; e.pc = e_pc; e.instr = e_instr; e.p4 = e_p4;
        e.chk_p4 = e_chk_p4; e.valid = e_valid; e.halted = e_halted;
        sb.push_back(e);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; load = ld;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.dut_b) begin
            cmp({tag, ".pc_f"},    pc_f_b,          e.pc);
            cmp({tag, ".instr_d"}, instr_d_b,       e.instr);
            if (e.chk_p4) cmp({tag, ".pc_plus4_d"}, p4_d_b, e.p4);
            cmp({tag, ".valid_d"}, {31'b0, valid_b},  {31'b0, e.valid});
            cmp({tag, ".halted"},  {31'b0, halted_b}, {31'b0, e.halted});
        end else begin
            cmp({tag, ".pc_f"},    pc_f_a,          e.pc);
            cmp({tag, ".instr_d"}, instr_d_a,       e.instr);
            if (e.chk_p4) cmp({tag, ".pc_plus4_d"}, p4_d_a, e.p4);
            cmp({tag, ".valid_d"}, {31'b0, valid_a},  {31'b0, e.valid});
            cmp({tag, ".halted"},  {31'b0, halted_a}, {31'b0, e.halted});
        end
    endtask

    initial begin
        // reset and free run
        step("reset",  1, 0, 0, 0, 1, 0, 32'h00, 32'h0,       32'h00, 1, 0, 0);
        step("run0",   0, 0, 0, 0, 1, 0, 32'h04, word(32'h00), 32'h04, 1, 1, 0);
        step("run1",   0, 0, 0, 0, 1, 0, 32'h08, word(32'h04), 32'h08, 1, 1, 0);
        step("run2",   0, 0, 0, 0, 1, 0, 32'h0C, word(32'h08), 32'h0C, 1, 1, 0);
        step("run3",   0, 0, 0, 0, 1, 0, 32'h10, word(32'h0C), 32'h10, 1, 1, 0);
        // stall 3 cycles at 0x10
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 0, 1, 0, 32'h10, word(32'h0C), 32'h10, 1, 1, 0);
        step("resume0", 0, 0, 0, 0, 1, 0, 32'h14, word(32'h10), 32'h14, 1, 1, 0);
        step("resume1", 0, 0, 0, 0, 1, 0, 32'h18, word(32'h14), 32'h18, 1, 1, 0);
        step("run4",    0, 0, 0, 0, 1, 0, 32'h1C, word(32'h18), 32'h1C, 1, 1, 0);
        step("run5",    0, 0, 0, 0, 1, 0, 32'h20, word(32'h1C), 32'h20, 1, 1, 0);
        // redirect with misaligned target
        step("redir",   0, 0, 1, 32'h43, 1, 0, 32'h40, 32'h0,  32'h0,  0, 0, 0);
        step("redir_t", 0, 0, 0, 0,      1, 0, 32'h44, word(32'h40), 32'h44, 1, 1, 0);
        // redirect under stall is ignored, then taken alone
        step("redir_stall", 0, 1, 1, 32'h80, 1, 0, 32'h44, word(32'h40), 32'h44, 1, 1, 0);
        step("redir2",      0, 0, 1, 32'h80, 1, 0, 32'h80, 32'h0, 32'h0, 0, 0, 0);
        // load=0 over a bubble is ignored
        step("load0_bub",   0, 0, 0, 0, 0, 0, 32'h84, word(32'h80), 32'h84, 1, 1, 0);
        // halt wins over stall and redirect
        step("halt",        0, 1, 1, 32'h200, 0, 0, 32'h84, 32'h0, 32'h84, 1, 0, 1);
        step("halt_redir",  0, 0, 1, 32'h100, 1, 0, 32'h84, 32'h0, 32'h84, 1, 0, 1);
        step("halt_stall",  0, 1, 0, 0,       1, 0, 32'h84, 32'h0, 32'h84, 1, 0, 1);
        step("halt_run",    0, 0, 0, 0,       1, 0, 32'h84, 32'h0, 32'h84, 1, 0, 1);
        step("halt_load0",  0, 0, 0, 0,       0, 0, 32'h84, 32'h0, 32'h84, 1, 0, 1);
        // reset overrides halt and a pending redirect
        step("rst_halt",    1, 0, 1, 32'h100, 1, 0, 32'h00, 32'h0, 32'h00, 1, 0, 0);
        step("post_rst",    0, 0, 0, 0,       1, 0, 32'h04, word(32'h00), 32'h04, 1, 1, 0);
        // wrap-around on the high-reset instance
        step("wrap_rst", 1, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0, 32'h0, 1, 0, 0);
        step("wrap0",    0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, word(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1, 1, 0);
        step("wrap1",    0, 0, 0, 0, 1, 1, 32'h0000_0000, word(32'hFFFF_FFFC), 32'h0000_0000, 1, 1, 0);
        step("wrap2",    0, 0, 0, 0, 1, 1, 32'h0000_0004, word(32'h0000_0000), 32'h0000_0004, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
